// File: rtl/alert_pkg.sv
// Shared types and limits for the alarm-clock timekeeping core.
package alert_pkg;

    typedef enum logic [2:0] {
        MODE_RUN          = 3'd0,
        MODE_SET_HOUR     = 3'd1,
        MODE_SET_MIN      = 3'd2,
        MODE_SET_ALM_HOUR = 3'd3,
        MODE_SET_ALM_MIN  = 3'd4
    } mode_t;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_RUN:          return MODE_SET_HOUR;
            MODE_SET_HOUR:     return MODE_SET_MIN;
            MODE_SET_MIN:      return MODE_SET_ALM_HOUR;
            MODE_SET_ALM_HOUR: return MODE_SET_ALM_MIN;
            default:           return MODE_RUN;
        endcase
    endfunction

    // Modulo increment shared by the minute/second and (zero-extended) hour fields.
    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
        return (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Prescaler: strobes tick while the count sits on its last value; hold parks it at zero.
module sec_tick_gen
    import alert_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // Combinational strobe so the parent can register sec_tick and the time on one edge.
    assign tick = !hold && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || hold || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alert_time_counter.sv
// Alarm-clock core: mode FSM, hh:mm:ss counters, alarm compare and ring timer.
//  state             | meaning
//  MODE_RUN          | time counts, inc ignored
//  MODE_SET_HOUR     | time frozen (sec=0), inc bumps hour
//  MODE_SET_MIN      | time frozen (sec=0), inc bumps minute
//  MODE_SET_ALM_HOUR | time counts, display shows alarm, inc bumps alarm hour
//  MODE_SET_ALM_MIN  | time counts, display shows alarm, inc bumps alarm minute
module alert_time_counter
    import alert_pkg::*;
#(
    parameter int CLK_DIV    = 50_000_000,
    parameter int ALARM_SECS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       alarm_en,
    input  logic       stop_btn,
    output logic [5:0] disp_sec,
    output logic [5:0] disp_min,
    output logic [4:0] disp_hour,
    output logic [2:0] mode,
    output logic       alarm_out,
    output logic       sec_tick
);

    localparam logic [5:0] RING_LOAD = 6'(ALARM_SECS);

    mode_t      mode_q, mode_d;
    logic       wrap, hold, inc_ok, trigger, alm_disp, alarm_d;
    logic [5:0] sec_q, sec_d, min_q, min_d, alm_min_q, alm_min_d, ring_q, ring_d;
    logic [4:0] hour_q, hour_d, alm_hour_q, alm_hour_d;

    assign hold = (mode_q == MODE_SET_HOUR) || (mode_q == MODE_SET_MIN);
    assign mode = mode_q;

    sec_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .hold (hold),
        .tick (wrap)
    );

    always_comb begin
        mode_d     = mode_btn ? next_mode(mode_q) : mode_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        alm_hour_d = alm_hour_q;
        alm_min_d  = alm_min_q;
        ring_d     = ring_q;
        alarm_d    = alarm_out;
        inc_ok     = inc_btn && !mode_btn;

        if (wrap) begin
            sec_d = inc_wrap(sec_q, SEC_MAX);
            if (sec_q == SEC_MAX) begin
                min_d = inc_wrap(min_q, MIN_MAX);
                if (min_q == MIN_MAX) begin
                    hour_d = 5'(inc_wrap({1'b0, hour_q}, {1'b0, HOUR_MAX}));
                end
            end
        end

        case (mode_q)
            MODE_SET_HOUR: begin
                sec_d = '0;
                if (inc_ok) hour_d = 5'(inc_wrap({1'b0, hour_q}, {1'b0, HOUR_MAX}));
            end
            MODE_SET_MIN: begin
                sec_d = '0;
                if (inc_ok) min_d = inc_wrap(min_q, MIN_MAX);
            end
            MODE_SET_ALM_HOUR: begin
                if (inc_ok) alm_hour_d = 5'(inc_wrap({1'b0, alm_hour_q}, {1'b0, HOUR_MAX}));
            end
            MODE_SET_ALM_MIN: begin
                if (inc_ok) alm_min_d = inc_wrap(alm_min_q, MIN_MAX);
            end
            default: ;
        endcase

        // Only a second tick can land on the setpoint; edits never trigger.
        trigger = wrap && alarm_en && (ring_q == '0) && (sec_d == '0)
                  && (min_d == alm_min_q) && (hour_d == alm_hour_q);

        if (stop_btn || !alarm_en) begin
            ring_d  = '0;
            alarm_d = 1'b0;
        end else if (trigger) begin
            ring_d  = RING_LOAD;
            alarm_d = 1'b1;
        end else if (wrap && (ring_q != '0)) begin
            ring_d  = ring_q - 6'd1;
            alarm_d = (ring_q != 6'd1);
        end

        alm_disp = (mode_d == MODE_SET_ALM_HOUR) || (mode_d == MODE_SET_ALM_MIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_RUN;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            alm_hour_q <= '0;
            alm_min_q  <= '0;
            ring_q     <= '0;
            alarm_out  <= 1'b0;
            sec_tick   <= 1'b0;
            disp_sec   <= '0;
            disp_min   <= '0;
            disp_hour  <= '0;
        end else begin
            mode_q     <= mode_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            alm_hour_q <= alm_hour_d;
            alm_min_q  <= alm_min_d;
            ring_q     <= ring_d;
            alarm_out  <= alarm_d;
            sec_tick   <= wrap;
            disp_sec   <= alm_disp ? 6'd0 : sec_d;
            disp_min   <= alm_disp ? alm_min_d : min_d;
            disp_hour  <= alm_disp ? alm_hour_d : hour_d;
        end
    end

endmodule

// File: tb/tb_alert_time_counter.sv
// Scenario bench for alert_time_counter with CLK_DIV=4, ALARM_SECS=3.
module tb_alert_time_counter;
    import alert_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int ALARM_SECS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1, mode_btn = 1'b0, inc_btn = 1'b0, alarm_en = 1'b0, stop_btn = 1'b0;
    logic [5:0] disp_sec, disp_min;
    logic [4:0] disp_hour;
    logic [2:0] mode;
    logic       alarm_out, sec_tick;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_cnt = 0;

    typedef struct packed {
        logic [2:0] mode;
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic       alarm;
    } val_t;

    typedef struct {
        int   tag;
        val_t v;
    } exp_t;

    exp_t sb[$];

    alert_time_counter #(.CLK_DIV(CLK_DIV), .ALARM_SECS(ALARM_SECS)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .alarm_en  (alarm_en),
        .stop_btn  (stop_btn),
        .disp_sec  (disp_sec),
        .disp_min  (disp_min),
        .disp_hour (disp_hour),
        .mode      (mode),
        .alarm_out (alarm_out),
        .sec_tick  (sec_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sec_tick === 1'b1) tick_cnt++;

    function automatic exp_t mk(int tag, logic [2:0] m, int h, int mi, int s, logic a);
        exp_t e;
        e.tag     = tag;
        e.v.mode  = m;
        e.v.hour  = 5'(h);
        e.v.min   = 6'(mi);
        e.v.sec   = 6'(s);
        e.v.alarm = a;
        return e;
    endfunction

    function automatic val_t obs();
        return {mode, disp_hour, disp_min, disp_sec, alarm_out};
    endfunction

    function automatic string fmt(val_t v);
        return $sformatf("mode=%0d %0d:%0d:%0d alarm=%0b", v.mode, v.hour, v.min, v.sec, v.alarm);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0; stop_btn = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic pulse_mode();
        mode_btn = 1'b1;
        cyc();
        mode_btn = 1'b0;
    endtask

    task automatic pulse_inc(int n);
        repeat (n) begin
            inc_btn = 1'b1;
            cyc();
            inc_btn = 1'b0;
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * CLK_DIV + 2; i++) begin
            cyc();
            if (sec_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reset, then alarm 00:01 set through the mode sequence, ending in RUN at 00:00:00.
    task automatic setup_alarm();
        alarm_en = 1'b0;
        do_reset();
        repeat (4) pulse_mode();
        pulse_inc(1);
        pulse_mode();
        alarm_en = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        sb.push_back(mk(0, MODE_RUN, 0, 0, 0, 1'b0));
        e = sb.pop_front();
        n_cmp++;
        if (obs() !== e.v || sec_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: got %s tick=%0b, expected %s tick=0", fmt(obs()), sec_tick, fmt(e.v));
        end
    endtask

    task automatic test_run_ticks();
        exp_t e;
        sb.delete();
        for (int k = 1; k <= 60; k++) sb.push_back(mk(CLK_DIV * k, MODE_RUN, 0, k / 60, k % 60, 1'b0));
        for (int c = 1; c <= 240; c++) begin
            cyc();
            if (sec_tick === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL run_ticks: unexpected tick at cycle %0d", c);
                end else begin
                    e = sb.pop_front();
                    if (c != e.tag || obs() !== e.v) begin
                        n_bad++;
                        $display("FAIL run_ticks: cycle %0d got %s, expected cycle %0d %s",
                                 c, fmt(obs()), e.tag, fmt(e.v));
                    end
                end
            end else if (sb.size() > 0 && sb[0].tag == c) begin
                n_cmp++;
                n_bad++;
                $display("FAIL run_ticks: missing tick at cycle %0d, got tick=%0b expected 1", c, sec_tick);
                void'(sb.pop_front());
            end
        end
        n_cmp++;
        if (sb.size() != 0 || disp_min !== 6'd1 || disp_sec !== 6'd0 || disp_hour !== 5'd0) begin
            n_bad++;
            $display("FAIL run_minute: got %s left=%0d, expected 0:1:0 left=0", fmt(obs()), sb.size());
        end
    endtask

    task automatic test_day_wrap();
        exp_t e;
        bit   ok;
        pulse_mode();
        pulse_inc(23);
        pulse_mode();
        pulse_inc(58);
        n_cmp++;
        if (obs() !== mk(0, MODE_SET_MIN, 23, 59, 0, 1'b0).v) begin
            n_bad++;
            $display("FAIL preload: got %s, expected mode=2 23:59:0 alarm=0", fmt(obs()));
        end
        repeat (3) pulse_mode();
        sb.delete();
        for (int i = 1; i <= 60; i++)
            sb.push_back(mk(i, MODE_RUN, (i < 60) ? 23 : 0, (i < 60) ? 59 : 0, i % 60, 1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(ok);
            n_cmp++;
            if (!ok || obs() !== e.v) begin
                n_bad++;
                $display("FAIL day_wrap tick %0d: got %s seen=%0b, expected %s", e.tag, fmt(obs()), ok, fmt(e.v));
            end
        end
    endtask

    task automatic test_set_wrap();
        exp_t e;
        sb.delete();
        pulse_mode();
        pulse_inc(5);
        pulse_mode();
        sb.push_back(mk(1, MODE_SET_MIN, 5, 59, 0, 1'b0));
        pulse_inc(59);
        e = sb.pop_front();
        n_cmp++;
        if (obs() !== e.v) begin
            n_bad++;
            $display("FAIL set_min59: got %s, expected %s", fmt(obs()), fmt(e.v));
        end
        sb.push_back(mk(2, MODE_SET_MIN, 5, 0, 0, 1'b0));
        pulse_inc(1);
        e = sb.pop_front();
        n_cmp++;
        if (obs() !== e.v) begin
            n_bad++;
            $display("FAIL set_min_wrap: got %s, expected %s", fmt(obs()), fmt(e.v));
        end
        sb.push_back(mk(3, MODE_SET_ALM_HOUR, 0, 0, 0, 1'b0));
        mode_btn = 1'b1; inc_btn = 1'b1;
        cyc();
        mode_btn = 1'b0; inc_btn = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (obs() !== e.v) begin
            n_bad++;
            $display("FAIL mode_and_inc: got %s, expected %s", fmt(obs()), fmt(e.v));
        end
        sb.push_back(mk(4, MODE_RUN, 5, 0, 0, 1'b0));
        repeat (2) pulse_mode();
        e = sb.pop_front();
        n_cmp++;
        if (obs() !== e.v) begin
            n_bad++;
            $display("FAIL mode_and_inc_time: got %s, expected %s", fmt(obs()), fmt(e.v));
        end
    endtask

    task automatic test_alarm_ring();
        exp_t e;
        bit   ok;
        setup_alarm();
        sb.delete();
        for (int k = 1; k <= 64; k++)
            sb.push_back(mk(k, MODE_RUN, 0, k / 60, k % 60, (k >= 60 && k < 60 + ALARM_SECS)));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(ok);
            n_cmp++;
            if (!ok || obs() !== e.v) begin
                n_bad++;
                $display("FAIL alarm_ring tick %0d: got %s seen=%0b, expected %s", e.tag, fmt(obs()), ok, fmt(e.v));
            end
        end
    endtask

    task automatic test_alarm_stop();
        exp_t e;
        bit   ok;
        setup_alarm();
        sb.delete();
        for (int k = 1; k <= 61; k++) sb.push_back(mk(k, MODE_RUN, 0, k / 60, k % 60, k >= 60));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(ok);
            n_cmp++;
            if (!ok || obs() !== e.v) begin
                n_bad++;
                $display("FAIL stop_pre tick %0d: got %s seen=%0b, expected %s", e.tag, fmt(obs()), ok, fmt(e.v));
            end
        end
        stop_btn = 1'b1;
        cyc();
        stop_btn = 1'b0;
        n_cmp++;
        if (alarm_out !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_clear: got alarm=%0b, expected 0", alarm_out);
        end
        wait_tick(ok);
        n_cmp++;
        if (!ok || obs() !== mk(62, MODE_RUN, 0, 1, 2, 1'b0).v) begin
            n_bad++;
            $display("FAIL stop_after: got %s seen=%0b, expected mode=0 0:1:2 alarm=0", fmt(obs()), ok);
        end
    endtask

    task automatic test_stop_vs_trigger();
        bit ok;
        setup_alarm();
        for (int k = 1; k <= 59; k++) begin
            wait_tick(ok);
            n_cmp++;
            if (!ok || disp_sec !== 6'(k)) begin
                n_bad++;
                $display("FAIL stop_race_pre tick %0d: got sec=%0d seen=%0b, expected sec=%0d", k, disp_sec, ok, k);
            end
        end
        repeat (CLK_DIV - 1) cyc();
        stop_btn = 1'b1;
        cyc();
        stop_btn = 1'b0;
        n_cmp++;
        if (sec_tick !== 1'b1 || obs() !== mk(60, MODE_RUN, 0, 1, 0, 1'b0).v) begin
            n_bad++;
            $display("FAIL stop_race: got %s tick=%0b, expected mode=0 0:1:0 alarm=0 tick=1", fmt(obs()), sec_tick);
        end
        wait_tick(ok);
        n_cmp++;
        if (!ok || alarm_out !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_race_after: got alarm=%0b seen=%0b, expected alarm=0", alarm_out, ok);
        end
    endtask

    task automatic test_alarm_display();
        int base;
        alarm_en = 1'b0;
        do_reset();
        base = tick_cnt;
        repeat (3) pulse_mode();
        pulse_inc(2);
        for (int c = 0; c < 40; c++) begin
            n_cmp++;
            if (obs() !== mk(c, MODE_SET_ALM_HOUR, 2, 0, 0, 1'b0).v) begin
                n_bad++;
                $display("FAIL alm_disp cycle %0d: got %s, expected mode=3 2:0:0 alarm=0", c, fmt(obs()));
            end
            cyc();
        end
        n_cmp++;
        if (tick_cnt - base != 10) begin
            n_bad++;
            $display("FAIL alm_disp_ticks: got %0d ticks, expected 10", tick_cnt - base);
        end
        repeat (2) pulse_mode();
        n_cmp++;
        if (obs() !== mk(0, MODE_RUN, 0, 0, 11, 1'b0).v) begin
            n_bad++;
            $display("FAIL alm_disp_return: got %s, expected mode=0 0:0:11 alarm=0", fmt(obs()));
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit all_ok;
        setup_alarm();
        all_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            wait_tick(ok);
            all_ok &= ok;
        end
        n_cmp++;
        if (!all_ok || alarm_out !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_ring: got alarm=%0b ticks_ok=%0b, expected alarm=1", alarm_out, all_ok);
        end
        repeat (2) pulse_mode();
        n_cmp++;
        if (mode !== MODE_SET_MIN || alarm_out !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_set: got mode=%0d alarm=%0b, expected mode=2 alarm=1", mode, alarm_out);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++;
        if (obs() !== mk(0, MODE_RUN, 0, 0, 0, 1'b0).v || sec_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: got %s tick=%0b, expected mode=0 0:0:0 alarm=0 tick=0", fmt(obs()), sec_tick);
        end
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_day_wrap();
        test_set_wrap();
        test_alarm_ring();
        test_alarm_stop();
        test_stop_vs_trigger();
        test_alarm_display();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
